// File: rtl/shift_pkg.sv
// Shared definitions for the shift-register sequencer: FSM encoding, direction codes, default widths.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package shift_pkg;

    localparam int W_DEF     = 8;
    localparam int AMT_W_DEF = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic DIR_RIGHT = 1'b0;
    localparam logic DIR_LEFT  = 1'b1;

endpackage

// File: rtl/shift_amt_counter.sv
// Loadable down-counter tracking the remaining shift edges of one request.
// Latency: flags reflect the registered count (load/decrement visible one cycle later).
// Backpressure: none; load has priority over enable.
//
// Ports: clk, rst (async active-low), load + load_val (capture amount),
//        en (decrement by one), is_one / is_zero (count flags).
module shift_amt_counter
    import shift_pkg::*;
#(
    parameter int AMT_W = AMT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             en,
    input  logic [AMT_W-1:0] load_val,
    output logic             is_one,
    output logic             is_zero
);

    logic [AMT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en) begin
            cnt <= cnt - AMT_W'(1);
        end
    end

    assign is_zero = (cnt == '0);
    assign is_one  = (cnt == AMT_W'(1));

endmodule

// File: rtl/shift_seq_ctrl.sv
// Sequencer driving an external bidirectional shift register through load/dr/IN for req_amt shift edges.
// Latency: result valid req_amt+2 cycles after request acceptance; one request per req_amt+3 cycles at best.
// Backpressure: res_ready low parks the FSM in DONE with the register self-reloading; req_ready only in IDLE.
//
// Ports: clk, rst (async active-low); request handshake req_valid/req_ready with
//        req_data/req_amt/req_dir; result handshake res_valid/res_ready with res_data;
//        shift register controls sr_load/sr_dr/sr_in and its state sr_q/sr_msb/sr_lsb.
// Build option SHIFT_SEQ_CARRY_EN adds res_carry, the last bit shifted out of the register.
module shift_seq_ctrl
    import shift_pkg::*;
#(
    parameter int W     = W_DEF,
    parameter int AMT_W = AMT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [W-1:0]     req_data,
    input  logic [AMT_W-1:0] req_amt,
    input  logic             req_dir,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [W-1:0]     res_data,
    output logic             sr_load,
    output logic             sr_dr,
    output logic [W-1:0]     sr_in,
    input  logic [W-1:0]     sr_q,
    input  logic             sr_msb,
    input  logic             sr_lsb
`ifdef SHIFT_SEQ_CARRY_EN
    ,
    output logic             res_carry
`endif
);

    state_t         state;
    state_t         state_nxt;
    logic [W-1:0]   data_q;
    logic           dir_q;
    logic [W-1:0]   hold_q;
    logic           cnt_one;
    logic           cnt_zero;
    logic           accept;

    assign accept = (state == IDLE) && req_valid;

    shift_amt_counter #(
        .AMT_W (AMT_W)
    ) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (accept),
        .en       (state == SHIFT),
        .load_val (req_amt),
        .is_one   (cnt_one),
        .is_zero  (cnt_zero)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            data_q <= '0;
            dir_q  <= DIR_RIGHT;
            hold_q <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                data_q <= req_data;
                dir_q  <= req_dir;
            end
            // Remember the final value so IDLE keeps reloading the register with it.
            if ((state == DONE) && res_ready) begin
                hold_q <= sr_q;
            end
        end
    end

    // The register has no hold mode, so every non-SHIFT state keeps load=1 and feeds back a stable value.
    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        res_valid = 1'b0;
        res_data  = '0;
        sr_load   = 1'b1;
        sr_dr     = DIR_RIGHT;
        sr_in     = hold_q;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                sr_in     = hold_q;
                if (req_valid) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                sr_in     = data_q;
                state_nxt = cnt_zero ? DONE : SHIFT;
            end
            SHIFT: begin
                sr_load = 1'b0;
                sr_dr   = dir_q;
                sr_in   = data_q;
                if (cnt_one) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                res_valid = 1'b1;
                res_data  = sr_q;
                sr_in     = sr_q;
                if (res_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

`ifdef SHIFT_SEQ_CARRY_EN
    logic carry_q;

    // The bit leaving the register on this edge: lsb for a right shift, msb for a left shift.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            carry_q <= 1'b0;
        end else if (state == LOAD) begin
            carry_q <= 1'b0;
        end else if (state == SHIFT) begin
            carry_q <= (dir_q == DIR_LEFT) ? sr_msb : sr_lsb;
        end
    end

    assign res_carry = (state == DONE) ? carry_q : 1'b0;
`else
    logic carry_unused;
    assign carry_unused = sr_msb ^ sr_lsb;
`endif

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Bench for shift_seq_ctrl: behavioural shift register, arithmetic reference model, scoreboard.
// Latency: checks result valid at acceptance + amt + 2 and accepts every cycle-exact handshake.
// Backpressure: res_ready driven randomly or held low to exercise DONE parking.
module tb_shift_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [7:0] req_data = 8'h00;
    logic [2:0] req_amt = 3'd0;
    logic       req_dir = 1'b0;
    logic       res_valid;
    logic       res_ready = 1'b1;
    logic [7:0] res_data;
    logic       sr_load;
    logic       sr_dr;
    logic [7:0] sr_in;
    logic [7:0] sr_q;
    logic       sr_msb;
    logic       sr_lsb;
    logic       res_carry;

    always #5 clk = ~clk;

    shift_seq_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data  (req_data),
        .req_amt   (req_amt),
        .req_dir   (req_dir),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .sr_load   (sr_load),
        .sr_dr     (sr_dr),
        .sr_in     (sr_in),
        .sr_q      (sr_q),
        .sr_msb    (sr_msb),
        .sr_lsb    (sr_lsb)
`ifdef SHIFT_SEQ_CARRY_EN
        ,
        .res_carry (res_carry)
`endif
    );

`ifndef SHIFT_SEQ_CARRY_EN
    assign res_carry = 1'b0;
`endif

    // The datapath register the sequencer controls: load, or arithmetic right / lsb-filling left shift.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)         sr_q <= 8'h00;
        else if (sr_load) sr_q <= sr_in;
        else if (sr_dr)   sr_q <= {sr_q[6:0], sr_q[0]};
        else              sr_q <= {sr_q[7], sr_q[7:1]};
    end
    assign sr_msb = sr_q[7];
    assign sr_lsb = sr_q[0];

    typedef struct {
        logic [7:0] data;
        logic       carry;
        int         acc;
        int         amt;
        int         sh0;
    } exp_t;

    exp_t       sb[$];
    int         tests = 0;
    int         fails = 0;
    int         cyc = 0;
    int         total_shifts = 0;
    int         rdy_pct = 100;
    logic [7:0] hold_exp = 8'h00;
    bit         in_res = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: shift by 'a' positions using plain arithmetic on the whole operand.
    function automatic logic [7:0] ref_shift(input logic [7:0] d, input int a, input logic dir);
        logic [31:0] fill;
        if (!dir) return 8'($signed(d) >>> a);
        fill = d[0] ? ((32'd1 << a) - 32'd1) : 32'd0;
        return 8'((32'(d) << a) | fill);
    endfunction

    // Reference: the last bit to leave the operand is the one 'a' positions in from the exit side.
    function automatic logic ref_carry(input logic [7:0] d, input int a, input logic dir);
        if (a == 0) return 1'b0;
        return dir ? d[8-a] : d[a-1];
    endfunction

    // Random result-side readiness.
    initial forever begin
        @(posedge clk);
        #1;
        res_ready = ($urandom_range(99) < rdy_pct);
    end

    // Scoreboard push: every accepted request queues its expected response.
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (!rst) begin
            sb.delete();
        end else if (req_valid && req_ready) begin
            e.data  = ref_shift(req_data, int'(req_amt), req_dir);
            e.carry = ref_carry(req_data, int'(req_amt), req_dir);
            e.acc   = cyc;
            e.amt   = int'(req_amt);
            e.sh0   = total_shifts;
            sb.push_back(e);
        end
    end

    // Monitor: pops and compares whenever the DUT presents a result.
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (!rst) begin
            in_res   = 1'b0;
            hold_exp = 8'h00;
        end else begin
            if (!sr_load) total_shifts++;
            if (!res_valid) begin
                check("res_data_idle_zero", 32'(res_data), 32'h0);
`ifdef SHIFT_SEQ_CARRY_EN
                check("res_carry_idle_zero", 32'(res_carry), 32'h0);
`endif
            end
            if (req_ready) begin
                check("idle_sr_load", 32'(sr_load), 32'h1);
                check("idle_sr_in_hold", 32'(sr_in), 32'(hold_exp));
                check("idle_sr_q_stable", 32'(sr_q), 32'(hold_exp));
            end
            if (res_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_res_valid", 32'(res_valid), 32'h0);
                end else begin
                    e = sb[0];
                    if (!in_res) begin
                        check("latency", 32'(cyc - e.acc), 32'(e.amt + 2));
                        in_res = 1'b1;
                    end
                    check("res_data", 32'(res_data), 32'(e.data));
                    check("done_sr_q", 32'(sr_q), 32'(e.data));
                    check("done_req_ready", 32'(req_ready), 32'h0);
`ifdef SHIFT_SEQ_CARRY_EN
                    check("res_carry", 32'(res_carry), 32'(e.carry));
`endif
                    if (res_ready) begin
                        check("shift_edges", 32'(total_shifts - e.sh0), 32'(e.amt));
                        hold_exp = e.data;
                        void'(sb.pop_front());
                        in_res = 1'b0;
                    end
                end
            end
        end
    end

    task automatic issue(input logic [7:0] d, input logic [2:0] a, input logic dir, output int acc);
        bit got = 1'b0;
        @(posedge clk);
        #1;
        req_valid = 1'b1;
        req_data  = d;
        req_amt   = a;
        req_dir   = dir;
        acc = -1;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clk);
            if (req_ready) begin
                got = 1'b1;
                acc = cyc;
            end
        end
        if (!got) check("issue_timeout", 32'h0, 32'h1);
    endtask

    task automatic drop();
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_valid(input int max);
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (res_valid) return;
        end
        check("wait_valid_timeout", 32'h0, 32'h1);
    endtask

    task automatic drain();
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && req_ready) return;
        end
        check("drain_timeout", 32'h0, 32'h1);
    endtask

    initial begin
        int a1;
        int a2;
        // Reset values.
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", 32'(req_ready), 32'h1);
        check("rst_res_valid", 32'(res_valid), 32'h0);
        check("rst_res_data", 32'(res_data), 32'h0);
        check("rst_sr_load", 32'(sr_load), 32'h1);
        check("rst_sr_in", 32'(sr_in), 32'h0);
        check("rst_sr_dr", 32'(sr_dr), 32'h0);
        @(negedge clk);
        rst = 1'b1;

        // Directed: right, left, zero amount.
        issue(8'h96, 3'd3, 1'b0, a1);
        drop();
        drain();
        issue(8'h35, 3'd2, 1'b1, a1);
        drop();
        drain();
        issue(8'hA5, 3'd0, 1'b0, a1);
        drop();
        drain();

        // Backpressure: park in DONE with a stray request pending.
        rdy_pct = 0;
        repeat (2) @(negedge clk);
        issue(8'h96, 3'd3, 1'b0, a1);
        @(posedge clk);
        #1;
        req_data = 8'h11;
        wait_valid(20);
        repeat (5) begin
            @(negedge clk);
            check("bp_res_data", 32'(res_data), 32'hF2);
            check("bp_sr_q", 32'(sr_q), 32'hF2);
            check("bp_req_ready", 32'(req_ready), 32'h0);
        end
        req_valid = 1'b0;
        rdy_pct = 100;
        drain();
        repeat (3) begin
            @(negedge clk);
            check("bp_after_sr_q", 32'(sr_q), 32'hF2);
            check("bp_after_req_ready", 32'(req_ready), 32'h1);
        end

        // Back-to-back with req_valid held.
        issue(8'h01, 3'd7, 1'b1, a1);
        issue(8'h80, 3'd7, 1'b0, a2);
        drop();
        drain();
        check("b2b_accept_spacing", 32'(a2 - a1), 32'd10);

        // Reset in the middle of a shift sequence.
        issue(8'h96, 3'd5, 1'b0, a1);
        drop();
        repeat (3) @(posedge clk);
        #2;
        check("pre_rst_shifting", 32'(sr_load), 32'h0);
        check("pre_rst_sr_q", 32'(sr_q), 32'(ref_shift(8'h96, 2, 1'b0)));
        rst = 1'b0;
        #1;
        check("midrst_req_ready", 32'(req_ready), 32'h1);
        check("midrst_res_valid", 32'(res_valid), 32'h0);
        check("midrst_sr_load", 32'(sr_load), 32'h1);
        check("midrst_sr_in", 32'(sr_in), 32'h0);
        check("midrst_sr_dr", 32'(sr_dr), 32'h0);
        @(negedge clk);
        #1;
        rst = 1'b1;

        // Randomized traffic with random result backpressure and idle gaps.
        for (int n = 0; n < 60; n++) begin
            rdy_pct = $urandom_range(100, 30);
            issue(8'($urandom), 3'($urandom_range(7)), 1'($urandom_range(1)), a1);
            if ($urandom_range(1) == 1) begin
                drop();
                repeat ($urandom_range(12)) @(posedge clk);
            end
        end
        drop();
        rdy_pct = 100;
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
